// File: rtl/multi_voice_tone_gen_if.sv
// Per-voice request/status bundle for the multi-voice tone generator.
interface multi_voice_tone_gen_if #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned DUR_W      = 10
);
  logic [NUM_VOICES-1:0]       start;
  logic [NUM_VOICES-1:0]       stop;
  logic [4*NUM_VOICES-1:0]     note_sel;
  logic [2*NUM_VOICES-1:0]     octave;
  logic [DUR_W*NUM_VOICES-1:0] dur_ms;
  logic [NUM_VOICES-1:0]       busy;
  logic [NUM_VOICES-1:0]       done;
  logic [NUM_VOICES-1:0]       voice_out;

  modport master (
    output start, stop, note_sel, octave, dur_ms,
    input  busy, done, voice_out
  );

  modport slave (
    input  start, stop, note_sel, octave, dur_ms,
    output busy, done, voice_out
  );
endinterface

// File: rtl/multi_voice_tone_gen.sv
// N-voice square-wave tone generator with ms-timed notes and a
// highest-index-wins priority mux onto a single buzzer pin.
module multi_voice_tone_gen #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned DUR_W      = 10,
  parameter int unsigned CNT_W      = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_voice_tone_gen_if.slave  bus,
  input  logic                   mute,
  output logic                   sound_out
);

  localparam int unsigned PRE_MAX = CLK_HZ / 1000 - 1;
  localparam int unsigned PRE_W   = $clog2(PRE_MAX + 1);

  typedef enum logic {IDLE, PLAY} state_t;

  function automatic longint unsigned note_freq(input int unsigned n);
    case (n)
      0:       return 64'd26163;
      1:       return 64'd29366;
      2:       return 64'd32963;
      3:       return 64'd34923;
      4:       return 64'd39200;
      5:       return 64'd44000;
      6:       return 64'd49388;
      7:       return 64'd52325;
      8:       return 64'd58733;
      9:       return 64'd65925;
      10:      return 64'd69846;
      11:      return 64'd78399;
      12:      return 64'd88000;
      13:      return 64'd98777;
      14:      return 64'd104650;
      default: return 64'd26163;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] half_period(input int unsigned n, input int unsigned o);
    longint unsigned h;
    h = (64'(CLK_HZ) * 64'd50 / note_freq(n)) >> o;
    if (h < 64'd2) h = 64'd2;
    return CNT_W'(h);
  endfunction

  // Constant lookup indexed by {note, octave}; rest entries are never used for toggling.
  logic [CNT_W-1:0] hp_tab [64];
  for (genvar i = 0; i < 64; i++) begin : g_hp
    assign hp_tab[i] = half_period(i / 4, i % 4);
  end

  logic [PRE_W-1:0]      pre;
  logic                  tick;
  state_t                state   [NUM_VOICES];
  logic [3:0]            note_q  [NUM_VOICES];
  logic [1:0]            oct_q   [NUM_VOICES];
  logic [DUR_W-1:0]      dur_cnt [NUM_VOICES];
  logic [CNT_W-1:0]      phase   [NUM_VOICES];
  logic [CNT_W-1:0]      hp_cur  [NUM_VOICES];
  logic [NUM_VOICES-1:0] busy_q;
  logic [NUM_VOICES-1:0] done_q;
  logic [NUM_VOICES-1:0] vout_q;
  logic                  sel;

  assign tick          = (pre == PRE_W'(PRE_MAX));
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.voice_out = vout_q;

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      hp_cur[v] = hp_tab[{note_q[v], oct_q[v]}];
    end
  end

  // Later (higher-index) busy voices override earlier ones.
  always_comb begin
    sel = 1'b0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (busy_q[v]) sel = vout_q[v];
    end
    if (mute) sel = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      sound_out <= 1'b0;
      busy_q    <= '0;
      done_q    <= '0;
      vout_q    <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        state[v]   <= IDLE;
        note_q[v]  <= '0;
        oct_q[v]   <= '0;
        dur_cnt[v] <= '0;
        phase[v]   <= '0;
      end
    end else begin
      pre       <= tick ? '0 : pre + PRE_W'(1);
      sound_out <= sel;
      done_q    <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (bus.stop[v]) begin
          // Stop beats a same-cycle start; in IDLE it is a no-op.
          if (state[v] == PLAY) begin
            state[v]  <= IDLE;
            busy_q[v] <= 1'b0;
            vout_q[v] <= 1'b0;
            phase[v]  <= '0;
          end
        end else if (bus.start[v]) begin
          state[v]   <= PLAY;
          busy_q[v]  <= 1'b1;
          vout_q[v]  <= 1'b0;
          phase[v]   <= '0;
          note_q[v]  <= bus.note_sel[4*v +: 4];
          oct_q[v]   <= bus.octave[2*v +: 2];
          dur_cnt[v] <= bus.dur_ms[DUR_W*v +: DUR_W];
        end else if (state[v] == PLAY) begin
          if (tick && dur_cnt[v] == DUR_W'(1)) begin
            state[v]   <= IDLE;
            busy_q[v]  <= 1'b0;
            vout_q[v]  <= 1'b0;
            phase[v]   <= '0;
            dur_cnt[v] <= '0;
            done_q[v]  <= 1'b1;
          end else begin
            if (tick && dur_cnt[v] != '0) dur_cnt[v] <= dur_cnt[v] - DUR_W'(1);
            if (phase[v] == hp_cur[v] - CNT_W'(1)) begin
              phase[v] <= '0;
              if (note_q[v] != 4'd15) vout_q[v] <= ~vout_q[v];
            end else begin
              phase[v] <= phase[v] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_voice_tone_gen.sv
// Directed bench for multi_voice_tone_gen at CLK_HZ=100000 (tick = 100 cycles).
module tb_multi_voice_tone_gen;

  logic clk = 1'b0;
  logic reset;
  logic mute;
  logic sound_out;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [3] = '{0, 0, 0};

  multi_voice_tone_gen_if #(.NUM_VOICES(3), .DUR_W(10)) bus ();

  multi_voice_tone_gen #(
    .CLK_HZ(100000),
    .NUM_VOICES(3),
    .DUR_W(10),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mute(mute),
    .sound_out(sound_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (bus.done[i]) done_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_voice(input int v, input logic [3:0] n, input logic [1:0] o, input logic [9:0] d);
    bus.note_sel[4*v +: 4] = n;
    bus.octave[2*v +: 2]   = o;
    bus.dur_ms[10*v +: 10] = d;
    bus.start[v]           = 1'b1;
    step();
    bus.start[v] = 1'b0;
  endtask

  task automatic stop_voice(input int v);
    bus.stop[v] = 1'b1;
    step();
    bus.stop[v] = 1'b0;
  endtask

  task automatic cycles_until(input int v, input logic lvl, output int n);
    n = 0;
    while (bus.voice_out[v] !== lvl && n < 2000) begin
      step();
      n++;
    end
  endtask

  // Runs until voice v drops busy; reports length, done pulses and any high voice_out.
  task automatic run_note(input int v, output int n, output int dones, output int highs);
    n = 0; dones = 0; highs = 0;
    do begin
      step();
      n++;
      if (bus.done[v]) begin
        dones++;
        check("busy_low_at_done", 32'(bus.busy[v]), 0);
      end
      if (bus.voice_out[v]) highs++;
    end while (bus.busy[v] && n < 1000);
  endtask

  initial begin
    int n, dones, highs, bad, base, prev;

    reset = 1'b1;
    mute  = 1'b0;
    bus.start = '0; bus.stop = '0; bus.note_sel = '0; bus.octave = '0; bus.dur_ms = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_vout",  32'(bus.voice_out), 0);
    check("rst_sound", 32'(sound_out), 0);

    // T1: A4, octave 0, endless
    base = done_cnt[0];
    start_voice(0, 4'd5, 2'd0, 10'd0);
    check("t1_busy", 32'(bus.busy[0]), 1);
    cycles_until(0, 1'b1, n);
    check("t1_rise", n, 113);
    check("t1_sound_lag", 32'(sound_out), 0);
    step();
    check("t1_sound_follow", 32'(sound_out), 1);
    cycles_until(0, 1'b0, n);
    check("t1_half", n + 1, 113);
    stop_voice(0);
    check("t1_stop_busy", 32'(bus.busy[0]), 0);
    check("t1_stop_vout", 32'(bus.voice_out[0]), 0);
    check("t1_no_done", done_cnt[0] - base, 0);

    // T2: octave shifts, second one as a retrigger
    start_voice(0, 4'd5, 2'd1, 10'd0);
    cycles_until(0, 1'b1, n);
    check("t2_oct1_rise", n, 56);
    cycles_until(0, 1'b0, n);
    check("t2_oct1_half", n, 56);
    start_voice(0, 4'd5, 2'd3, 10'd0);
    cycles_until(0, 1'b1, n);
    check("t2_oct3_rise", n, 14);
    stop_voice(0);

    // T3: 3 ms timed note
    base = done_cnt[0];
    start_voice(0, 4'd5, 2'd0, 10'd3);
    run_note(0, n, dones, highs);
    check("t3_len_in_range", 32'(n >= 201 && n <= 300), 1);
    check("t3_done_once", dones, 1);
    repeat (5) step();
    check("t3_done_total", done_cnt[0] - base, 1);

    // T4: priority mux, then drop voice 2
    start_voice(0, 4'd5, 2'd0, 10'd0);
    start_voice(2, 4'd7, 2'd0, 10'd0);
    cycles_until(2, 1'b1, n);
    check("t4_v2_rise", n, 95);
    bad = 0;
    prev = bus.voice_out[2];
    for (int k = 0; k < 300; k++) begin
      step();
      if (sound_out !== 1'(prev)) bad++;
      prev = bus.voice_out[2];
    end
    check("t4_track_v2", bad, 0);
    base = done_cnt[2];
    stop_voice(2);
    check("t4_v2_idle", 32'(bus.busy[2]), 0);
    bad = 0;
    prev = bus.voice_out[0];
    for (int k = 0; k < 250; k++) begin
      step();
      if (sound_out !== 1'(prev)) bad++;
      prev = bus.voice_out[0];
    end
    check("t4_track_v0", bad, 0);
    check("t4_no_done2", done_cnt[2] - base, 0);
    mute = 1'b1;
    step();
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      step();
      if (sound_out !== 1'b0) bad++;
    end
    check("t4_mute_sound", bad, 0);
    check("t4_mute_busy", 32'(bus.busy[0]), 1);
    mute = 1'b0;
    stop_voice(0);

    // T5: start+stop together, retrigger mid-note, rest note
    bus.start[1] = 1'b1;
    bus.stop[1]  = 1'b1;
    step();
    bus.start[1] = 1'b0;
    bus.stop[1]  = 1'b0;
    check("t5_stop_wins", 32'(bus.busy[1]), 0);
    start_voice(1, 4'd5, 2'd0, 10'd0);
    repeat (150) step();
    check("t5_high_before", 32'(bus.voice_out[1]), 1);
    base = done_cnt[1];
    start_voice(1, 4'd0, 2'd0, 10'd0);
    check("t5_retrig_low", 32'(bus.voice_out[1]), 0);
    cycles_until(1, 1'b1, n);
    check("t5_c4_rise", n, 191);
    check("t5_no_done", done_cnt[1] - base, 0);
    stop_voice(1);
    start_voice(1, 4'd15, 2'd0, 10'd2);
    run_note(1, n, dones, highs);
    check("t5_rest_len", 32'(n >= 101 && n <= 200), 1);
    check("t5_rest_silent", highs, 0);
    check("t5_rest_done", dones, 1);

    // T6: async reset mid-note with mute, then prescaler restart
    start_voice(0, 4'd5, 2'd0, 10'd5);
    repeat (150) step();
    mute  = 1'b1;
    reset = 1'b1;
    #1;
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_done", 32'(bus.done), 0);
    check("t6_vout", 32'(bus.voice_out), 0);
    check("t6_sound", 32'(sound_out), 0);
    step();
    bus.note_sel[3:0] = 4'd5;
    bus.octave[1:0]   = 2'd0;
    bus.dur_ms[9:0]   = 10'd1;
    bus.start[0]      = 1'b1;
    reset = 1'b0;
    mute  = 1'b0;
    step();
    bus.start[0] = 1'b0;
    run_note(0, n, dones, highs);
    check("t6_presc_restart", n, 99);
    check("t6_done", dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
